msk_and_hpc2_pipe: RTL and testbench

- W-bit-wide, d-share masked AND built from HPC2 slices (one slice per bit).
- Valid/ready handshaking on operands, randomness and result, with a runtime swap of which operand goes through the refreshed (delayed) path.
- Operands arrive together; the block registers internally, so callers need no pre-aligned "prev" copies.
- Sits between masked S-box datapaths and the PRNG front end, replacing hand-wired fixed-latency gadget instances where stalls occur.

---
 rtl/msk_and_hpc2_pipe_pkg.sv | 18 +
 rtl/msk_and_hpc2_slice.sv | 104 ++++++++++
 rtl/msk_and_hpc2_pipe.sv | 101 ++++++++++
 tb/tb_msk_and_hpc2_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_and_hpc2_pipe_pkg.sv
// Shared helpers for the masked HPC2 AND pipeline: randomness count,
// lexicographic pair indexing and the share/lane bit layout.
package msk_pkg;

    function automatic int hpc2rnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Pair (i,j) with i<j, numbered in lexicographic order.
    function automatic int pidx(input int i, input int j, input int d);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic int shbit(input int i, input int k, input int w);
        return i * w + k;
    endfunction

endpackage

// File: rtl/msk_and_hpc2_slice.sv
// One HPC2 AND lane over d shares, two register stages with independent
// enables; swap picks which operand travels the refreshed path.
module msk_and_hpc2_slice
    import msk_pkg::*;
#(
    parameter int d = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en1,
    input  logic                  en2,
    input  logic                  swap,
    input  logic [d-1:0]          a,
    input  logic [d-1:0]          b,
    input  logic [hpc2rnd(d)-1:0] r,
    output logic [d-1:0]          out
);

    localparam int NP = hpc2rnd(d);

    logic [d-1:0]          x;
    logic [d-1:0]          y;
    logic [d-1:0][d-1:0]   u_next;
    logic [d-1:0][d-1:0]   s1_u;
    logic [NP-1:0]         s1_r;
    logic [d-1:0]          s1_x;
    logic [d-1:0]          s1_y;
    logic [d-1:0]          xy_next;
    logic [d-1:0][d-1:0]   nr_next;
    logic [d-1:0][d-1:0]   yu_next;
    logic [d-1:0]          s2_xy;
    logic [d-1:0][d-1:0]   s2_nr;
    logic [d-1:0][d-1:0]   s2_yu;

    assign x = swap ? a : b;
    assign y = swap ? b : a;

    // Each u_ij mixes exactly one share with one random bit; diagonal stays 0.
    always_comb begin
        u_next = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i < j) begin
                    u_next[i][j] = x[j] ^ r[pidx(i, j, d)];
                end else if (i > j) begin
                    u_next[i][j] = x[j] ^ r[pidx(j, i, d)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_u <= '0;
            s1_r <= '0;
            s1_x <= '0;
            s1_y <= '0;
        end else if (en1) begin
            s1_u <= u_next;
            s1_r <= r;
            s1_x <= x;
            s1_y <= y;
        end
    end

    always_comb begin
        xy_next = s1_y & s1_x;
        nr_next = '0;
        yu_next = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                yu_next[i][j] = s1_y[i] & s1_u[i][j];
                if (i < j) begin
                    nr_next[i][j] = ~s1_y[i] & s1_r[pidx(i, j, d)];
                end else if (i > j) begin
                    nr_next[i][j] = ~s1_y[i] & s1_r[pidx(j, i, d)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_xy <= '0;
            s2_nr <= '0;
            s2_yu <= '0;
        end else if (en2) begin
            s2_xy <= xy_next;
            s2_nr <= nr_next;
            s2_yu <= yu_next;
        end
    end

    // Output share compression only ever reads registered terms.
    always_comb begin
        out = s2_xy;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                out[i] = out[i] ^ s2_nr[i][j] ^ s2_yu[i][j];
            end
        end
    end

endmodule

// File: rtl/msk_and_hpc2_pipe.sv
// W-lane, d-share masked AND with valid/ready on operands, randomness and
// result; two-stage elastic pipeline around HPC2 slices.
module msk_and_hpc2_pipe
    import msk_pkg::*;
#(
    parameter int d          = 2,
    parameter int W          = 1,
    parameter int SHIDX_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W*d-1:0]          in_a,
    input  logic [W*d-1:0]          in_b,
    input  logic                    swap,
    input  logic                    rnd_valid,
    output logic                    rnd_ready,
    input  logic [W*hpc2rnd(d)-1:0] rnd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W*d-1:0]          out,
    output logic                    busy
);

    localparam int NP = hpc2rnd(d);

    if (d < 2 || (d - 1) >= (1 << SHIDX_BITS)) begin : g_bad_param
        $error("msk_and_hpc2_pipe: d must be >= 2 and d-1 must fit in SHIDX_BITS");
    end

    logic s1_v;
    logic s2_v;
    logic adv1;
    logic fire_in;
    logic en2;

    // Randomness is only taken together with an operand pair.
    assign adv1      = ~s2_v | out_ready;
    assign in_ready  = ~rst & rnd_valid & (~s1_v | adv1);
    assign fire_in   = in_valid & in_ready;
    assign rnd_ready = fire_in;
    assign en2       = s1_v & adv1;
    assign out_valid = s2_v;
    assign busy      = s1_v | s2_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (adv1) begin
                s2_v <= s1_v;
            end
            if (fire_in) begin
                s1_v <= 1'b1;
            end else if (adv1) begin
                s1_v <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_lane
        logic [d-1:0]  a_l;
        logic [d-1:0]  b_l;
        logic [d-1:0]  o_l;
        logic [NP-1:0] r_l;

        always_comb begin
            a_l = '0;
            b_l = '0;
            r_l = '0;
            for (int i = 0; i < d; i++) begin
                a_l[i] = in_a[shbit(i, k, W)];
                b_l[i] = in_b[shbit(i, k, W)];
            end
            for (int p = 0; p < NP; p++) begin
                r_l[p] = rnd[shbit(p, k, W)];
            end
        end

        msk_and_hpc2_slice #(
            .d(d)
        ) u_slice (
            .clk  (clk),
            .rst  (rst),
            .en1  (fire_in),
            .en2  (en2),
            .swap (swap),
            .a    (a_l),
            .b    (b_l),
            .r    (r_l),
            .out  (o_l)
        );

        for (genvar i = 0; i < d; i++) begin : g_share
            assign out[shbit(i, k, W)] = o_l[i];
        end
    end

endmodule

// File: tb/tb_msk_and_hpc2_pipe.sv
// Randomized self-checking bench for msk_and_hpc2_pipe (d=3, W=4) against an
// algebraic share-level model plus a transaction queue.
module tb_msk_and_hpc2_pipe;

    localparam int D  = 3;
    localparam int W  = 4;
    localparam int NP = D * (D - 1) / 2;
    localparam int NB = W * D;
    localparam int RB = W * NP;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_a;
    logic [NB-1:0] in_b;
    logic          swap;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [RB-1:0] rnd;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] out;
    logic          busy;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     ready_mode = 0;
    logic   after_rst = 1'b0;
    longint last_acc_cyc = 0;

    typedef struct {
        logic [NB-1:0] shares;
        logic [W-1:0]  plain;
        longint        cyc;
    } exp_t;

    exp_t q[$];

    msk_and_hpc2_pipe #(
        .d(D),
        .W(W),
        .SHIDX_BITS(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .swap      (swap),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Share i of the product: y_i x_i plus, for every other share j, r_ij ^ y_i x_j.
    function automatic logic [NB-1:0] model_out(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                                input logic [RB-1:0] r, input logic sw);
        logic [NB-1:0] res;
        logic          x[D];
        logic          y[D];
        logic          rt[D][D];
        logic          s;
        int            p;
        res = '0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < D; i++) begin
                x[i] = sw ? a[i*W+k] : b[i*W+k];
                y[i] = sw ? b[i*W+k] : a[i*W+k];
                rt[i][i] = 1'b0;
            end
            p = 0;
            for (int i = 0; i < D; i++) begin
                for (int j = i + 1; j < D; j++) begin
                    rt[i][j] = r[p*W+k];
                    rt[j][i] = r[p*W+k];
                    p++;
                end
            end
            for (int i = 0; i < D; i++) begin
                s = y[i] & x[i];
                for (int j = 0; j < D; j++) begin
                    if (j != i) s = s ^ rt[i][j] ^ (y[i] & x[j]);
                end
                res[i*W+k] = s;
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [NB-1:0] v);
        logic [W-1:0] u;
        u = '0;
        for (int i = 0; i < D; i++) u = u ^ v[i*W +: W];
        return u;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout expected handshake (cycle %0d)", name, cyc);
    endtask

    // Per-cycle comparison against the queue model, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        exp_t e;
        if (rst) begin
            check_output("in_ready_rst", 32'(in_ready), 32'd0);
            check_output("rnd_ready_rst", 32'(rnd_ready), 32'd0);
            q.delete();
            after_rst = 1'b1;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            exp_ready = rnd_valid && ((q.size() < 2) || out_ready);
            check_output("out_valid", 32'(out_valid), 32'(exp_valid));
            check_output("busy", 32'(busy), 32'(q.size() > 0));
            check_output("in_ready", 32'(in_ready), 32'(exp_ready));
            check_output("rnd_ready", 32'(rnd_ready), 32'(in_valid && exp_ready));
            if (after_rst) check_output("out_after_rst", 32'(out), 32'd0);
            after_rst = 1'b0;
            if (exp_valid) begin
                check_output("out_shares", 32'(out), 32'(q[0].shares));
                check_output("out_plain", 32'(unmask(out)), 32'(q[0].plain));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_ready) begin
                e.shares = model_out(in_a, in_b, rnd, swap);
                e.plain  = unmask(in_a) & unmask(in_b);
                e.cyc    = cyc;
                q.push_back(e);
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Presents one operand pair; randomness shows up rnd_delay cycles late.
    task automatic apply_stimulus(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                  input logic [RB-1:0] r, input logic sw,
                                  input int rnd_delay, output int waited);
        waited    = 0;
        in_a      = a;
        in_b      = b;
        rnd       = r;
        swap      = sw;
        in_valid  = 1'b1;
        rnd_valid = (rnd_delay == 0);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (waited > 300) begin
                timeout_fail("accept_wait");
                break;
            end
            @(posedge clk);
            #2;
            waited++;
            if (waited >= rnd_delay) rnd_valid = 1'b1;
        end
        last_acc_cyc = cyc;
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [NB-1:0] exp_out, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) timeout_fail(name);
        else check_output(name, 32'(out), 32'(exp_out));
    endtask

    initial begin
        int            w;
        int            lat;
        longint        first_acc;
        logic [NB-1:0] held;

        rst       = 1'b1;
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        in_a      = '0;
        in_b      = '0;
        rnd       = '0;
        swap      = 1'b0;

        check_output("model_pin_r0", 32'(model_out(12'h00F, 12'h0F0, 12'h000, 1'b0)), 32'h00F);
        check_output("model_pin_swap", 32'(model_out(12'h00F, 12'h0F0, 12'h000, 1'b1)), 32'h0F0);
        check_output("model_pin_r01", 32'(model_out(12'h00F, 12'h0F0, 12'h00F, 1'b0)), 32'h0F0);

        repeat (3) @(posedge clk);
        #2;
        rst       = 1'b0;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        @(negedge clk);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_out", 32'(out), 32'd0);
        @(posedge clk);
        #2;

        $display("[TB] directed transactions");
        apply_stimulus(12'h00F, 12'h0F0, 12'h000, 1'b0, 0, w);
        wait_out("dir_r0", 12'h00F, lat);
        check_output("dir_latency", 32'(lat), 32'd2);
        @(posedge clk); #2;
        apply_stimulus(12'h00F, 12'h0F0, 12'h00F, 1'b0, 0, w);
        wait_out("dir_r01", 12'h0F0, lat);
        @(posedge clk); #2;
        apply_stimulus(12'h00F, 12'h0F0, 12'h000, 1'b1, 0, w);
        wait_out("dir_swap", 12'h0F0, lat);
        check_output("dir_plain", 32'(unmask(out)), 32'h00F);
        @(posedge clk); #2;

        $display("[TB] back-to-back stream");
        first_acc = 0;
        for (int n = 0; n < 8; n++) begin
            apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'($urandom()), 0, w);
            if (n == 0) first_acc = last_acc_cyc;
        end
        check_output("stream_span", 32'(last_acc_cyc - first_acc), 32'd7);
        repeat (4) @(posedge clk);
        #2;

        $display("[TB] stall with both stages full");
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #2;
        apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'b0, 0, w);
        apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'b1, 0, w);
        fork
            apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'b0, 0, w);
            begin
                repeat (2) @(negedge clk);
                held = out;
                repeat (5) begin
                    @(negedge clk);
                    check_output("stall_hold", 32'(out), 32'(held));
                    check_output("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        repeat (4) @(posedge clk);
        #2;

        $display("[TB] randomness arriving late");
        apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'b0, 3, w);
        check_output("rnd_late_wait", 32'(w), 32'd3);
        repeat (3) @(posedge clk);
        #2;

        $display("[TB] reset with both stages full");
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #2;
        apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'b0, 0, w);
        apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'b1, 0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        ready_mode = 0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_out", 32'(out), 32'd0);
        @(posedge clk);
        #2;
        apply_stimulus(12'h00F, 12'h0F0, 12'h00F, 1'b0, 0, w);
        wait_out("post_rst_out", 12'h0F0, lat);
        check_output("post_rst_latency", 32'(lat), 32'd2);
        @(posedge clk);
        #2;

        $display("[TB] random traffic with backpressure");
        ready_mode = 2;
        for (int n = 0; n < 60; n++) begin
            apply_stimulus(NB'($urandom()), NB'($urandom()), RB'($urandom()), 1'($urandom()),
                           $urandom_range(0, 2), w);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;

        for (int t = 0; t < 50 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) timeout_fail("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
